// File: rtl/act_pkg.sv
// Shared definitions for the activation stage: mode encodings and fixed-point
// constants derived from the sample width and fractional bit count.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_RELU   = 2'b01,
    MODE_LEAKY  = 2'b10,
    MODE_RELU6  = 2'b11
  } act_mode_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // 6.0 in the given format, clamped when it cannot be represented.
  function automatic longint six_val(input int w, input int f);
    longint six;
    six = longint'(6) <<< f;
    return (six > sat_max(w)) ? sat_max(w) : six;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation (bypass / ReLU / leaky / ReLU6).
// Sign and leaky-shifted value arrive precomputed from the previous stage.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic                     x_neg,
  input  logic signed [DATA_W-1:0] x_shr,
  input  logic        [1:0]        mode,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [DATA_W-1:0] SIX = DATA_W'(six_val(DATA_W, FRAC_W));

  always_comb begin
    y = x;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_RELU:   y = x_neg ? '0 : x;
      MODE_LEAKY:  y = x_neg ? x_shr : x;
      MODE_RELU6: begin
        if (x_neg)         y = '0;
        else if (x > SIX)  y = SIX;
        else               y = x;
      end
      default:     y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// LANES-wide activation stage, 2-cycle latency, 1 beat/cycle; in_ready = stage-1 advance (no skid).
// Optional ACT_SPARSITY_STATS_EN adds stat_clr/zero_cnt (saturating count of zero output lanes).
module act_pipe
  import act_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data
`ifdef ACT_SPARSITY_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [31:0]               zero_cnt
`endif
);

  localparam int W = LANES * DATA_W;

  logic           s1_valid, s2_valid;
  logic           s1_adv, s2_adv;
  logic [1:0]     s1_mode;
  logic [W-1:0]   s1_data, s1_shr, s2_data;
  logic [W-1:0]   in_shr, lane_y;
  logic [LANES-1:0] s1_neg, in_neg;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] x_in;
    assign x_in = $signed(in_data[g*DATA_W +: DATA_W]);
    assign in_neg[g] = x_in[DATA_W-1];
    // Shift is done ahead of S1 so stage 2 is a plain select.
    assign in_shr[g*DATA_W +: DATA_W] = x_in >>> LEAKY_SHIFT;

    act_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x     (s1_data[g*DATA_W +: DATA_W]),
      .x_neg (s1_neg[g]),
      .x_shr (s1_shr[g*DATA_W +: DATA_W]),
      .mode  (s1_mode),
      .y     (lane_y[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_data  <= '0;
      s1_shr   <= '0;
      s1_neg   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_data <= in_data;
          s1_shr  <= in_shr;
          s1_neg  <= in_neg;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= lane_y;
      end
    end
  end

`ifdef ACT_SPARSITY_STATS_EN
  localparam int ZL_W = $clog2(LANES + 1);

  logic [ZL_W-1:0] zero_lanes;
  logic [32:0]     cnt_sum;

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_data[i*DATA_W +: DATA_W] == '0) zero_lanes = zero_lanes + ZL_W'(1);
    end
    cnt_sum = {1'b0, zero_cnt} + 33'(zero_lanes);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                     zero_cnt <= '0;
    else if (stat_clr)              zero_cnt <= '0;
    else if (out_valid && out_ready) zero_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
`endif

endmodule

// File: doc/act_pipe.md
Name: act_pipe

Overview:
Parametrised, pipelined activation stage for the CNN datapath; successor to the single-lane combinational ReLU.
- Processes LANES signed fixed-point values per beat, with a per-beat selectable mode: bypass, ReLU, leaky ReLU or ReLU6.
- Sits between the convolution/accumulate output and the pooling stage.
- Uses valid/ready streaming handshakes on both sides.

Parameters:
DATA_W, 16, width of each lane sample (two's complement)
FRAC_W, 8, fractional bits; default format is Q8.8
LANES, 4, parallel lanes per beat
LEAKY_SHIFT, 3, leaky slope is 2^-LEAKY_SHIFT (default 0.125)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_mode  in  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 ReLU6; sampled with the beat
in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  LANES*DATA_W  activated lanes, same packing as in_data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - While rst_n=0 at a clk edge: all stage valids clear to 0 and all data registers clear to 0.
  - Outputs after reset: out_valid=0, out_data=0, in_ready=1.
- Transfer rules:
  - An input beat transfers when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
- Pipeline: two register stages, S1 and S2. Latency is exactly 2 cycles from input transfer to out_valid with no stall.
  - S1 captures in_data and in_mode, plus per-lane sign and precomputed leaky shift.
  - S2 holds the final result, which drives out_data.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - Sustains 1 beat/cycle when out_ready is held 1.
- Stall: while out_ready=0 and out_valid=1, out_data and out_valid hold stable; no beat is dropped or duplicated.
- Per-lane arithmetic for x, signed DATA_W:
  - bypass: y = x.
  - ReLU: y = x if x>0, else 0. Zero maps to 0.
  - leaky: y = x if x>=0, else x >>> LEAKY_SHIFT (arithmetic shift, rounds toward -inf, so -1 gives -1).
  - ReLU6: y = 0 if x<0; y = SIX if x>SIX; else x. SIX = 6<<FRAC_W, saturated to the max positive value if it does not fit in DATA_W.
- Boundaries:
  - The most negative input (0x8000 at default width) gives 0 for ReLU/ReLU6 and 0xF000 for leaky.
  - Max positive (0x7FFF) passes unchanged in ReLU and is clamped to 0x0600 in ReLU6.
- Mode travels with its beat: a mode change between consecutive beats affects only later beats.
- Lanes are fully independent; no cross-lane arithmetic.
- Reset mid-stream flushes S1 and S2. In-flight beats are discarded, not emitted.

Optional Feature:
Macro ACT_SPARSITY_STATS_EN.
- When defined, adds ports:
  - stat_clr (in, 1)
  - zero_cnt (out, 32)
- zero_cnt counts output lanes equal to 0 on each output transfer (adds 0..LANES per transfer).
- The counter saturates at 0xFFFFFFFF.
- stat_clr=1 zeroes the counter and takes priority over a simultaneous increment. Reset also zeroes it.
- When not defined, these ports and the counter logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package act_pkg holds:
  - mode encodings: MODE_BYPASS=2'b00, MODE_RELU=2'b01, MODE_LEAKY=2'b10, MODE_RELU6=2'b11
  - fixed-point helpers: the SIX constant and max/min saturation values derived from DATA_W/FRAC_W.
- One sub-module, act_lane: single-lane combinational activation function (x, mode -> y). It is instantiated LANES times in a generate loop. Pipeline registers and handshake stay in act_pipe.

Test Plan:
- ReLU, LANES=4, out_ready=1: lanes {0x0300, 0xFE00, 0x0000, 0x0700} give {0x0300, 0x0000, 0x0000, 0x0700}, out_valid exactly 2 cycles after the input transfer.
- Leaky: lanes {0xFE00 (-2.0), 0xFFFF, 0x8000, 0x0100} give {0xFFC0 (-0.25), 0xFFFF, 0xF000, 0x0100}.
- ReLU6: lanes {0x0700, 0x0600, 0x05FF, 0xFB00} give {0x0600, 0x0600, 0x05FF, 0x0000}; bypass returns the inputs unchanged.
- Backpressure: stream 8 beats with random modes, out_ready=0 for 5 cycles mid-stream.
  - in_ready drops after S1 and S2 fill; out_data stays stable while stalled.
  - All 8 results arrive in order against a reference model.
- Reset mid-operation: assert rst_n=0 for 1 cycle with both stages full.
  - Next cycle out_valid=0, out_data=0, in_ready=1; no stale beat emitted.
- ACT_SPARSITY_STATS_EN: 3 ReLU beats with 2, 4 and 0 zero lanes give zero_cnt=6; stat_clr together with a transfer gives 0.
